// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / mul-div hazard stalls, exception flush and refill sequencing
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        reset,
  input  logic [4:0]  D_rs,
  input  logic [4:0]  D_rt,
  input  logic        D_use_rs,
  input  logic        D_use_rt,
  input  logic [4:0]  E_A3,
  input  logic        E_RegWrite,
  input  logic        E_MemtoReg,
  input  logic [4:0]  M_A3,
  input  logic        M_RegWrite,
  input  logic        M_MemtoReg,
  input  logic [1:0]  E_md_start,
  input  logic        D_is_md,
  input  logic        exc_req,
  output logic        stall_F,
  output logic        stall_D,
  output logic        flush_E,
  output logic        flush_all,
  output logic        md_busy,
  output logic [3:0]  md_cnt,
  output logic [15:0] stall_cycles
);
  typedef enum logic [1:0] {IDLE, MD_BUSY, REFILL} state_t;
  state_t state, state_nx;
  logic [3:0] cnt_nx;
  logic e_lu, m_lu, md_go, stall;
  assign e_lu = E_RegWrite & E_MemtoReg & (E_A3 != 5'd0) &
                ((D_use_rs & (D_rs == E_A3)) | (D_use_rt & (D_rt == E_A3)));
  assign m_lu = M_RegWrite & M_MemtoReg & (M_A3 != 5'd0) &
                ((D_use_rs & (D_rs == M_A3)) | (D_use_rt & (D_rt == M_A3)));
  // 2'b11 decodes as no operation
  assign md_go = E_md_start[0] ^ E_md_start[1];
  assign flush_all = exc_req;
  assign stall = (e_lu | m_lu | (D_is_md & (md_busy | md_go))) & ~flush_all & (state != REFILL);
  assign stall_F = stall;
  assign stall_D = stall;
  assign flush_E = stall;
  always_comb begin
    cnt_nx = (state == IDLE && md_go && !exc_req) ? (E_md_start[1] ? 4'd10 : 4'd5)
                                                  : md_cnt - {3'b0, md_cnt != 4'd0};
    state_nx = exc_req ? REFILL : (cnt_nx != 4'd0 ? MD_BUSY : IDLE);
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= IDLE;
      md_cnt       <= 4'd0;
      md_busy      <= 1'b0;
      stall_cycles <= 16'd0;
    end else begin
      state        <= state_nx;
      md_cnt       <= cnt_nx;
      md_busy      <= cnt_nx != 4'd0;
      stall_cycles <= stall_cycles + {15'd0, stall & ~&stall_cycles};
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenario bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic        CLK = 1'b0;
  logic        reset;
  logic [4:0]  D_rs, D_rt, E_A3, M_A3;
  logic        D_use_rs, D_use_rt, E_RegWrite, E_MemtoReg, M_RegWrite, M_MemtoReg;
  logic [1:0]  E_md_start;
  logic        D_is_md, exc_req;
  logic        stall_F, stall_D, flush_E, flush_all, md_busy;
  logic [3:0]  md_cnt;
  logic [15:0] stall_cycles;
  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl dut (
    .CLK(CLK), .reset(reset), .D_rs(D_rs), .D_rt(D_rt), .D_use_rs(D_use_rs), .D_use_rt(D_use_rt),
    .E_A3(E_A3), .E_RegWrite(E_RegWrite), .E_MemtoReg(E_MemtoReg),
    .M_A3(M_A3), .M_RegWrite(M_RegWrite), .M_MemtoReg(M_MemtoReg),
    .E_md_start(E_md_start), .D_is_md(D_is_md), .exc_req(exc_req),
    .stall_F(stall_F), .stall_D(stall_D), .flush_E(flush_E), .flush_all(flush_all),
    .md_busy(md_busy), .md_cnt(md_cnt), .stall_cycles(stall_cycles)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    reset = 1'b0; D_rs = 0; D_rt = 0; D_use_rs = 0; D_use_rt = 0;
    E_A3 = 0; E_RegWrite = 0; E_MemtoReg = 0; M_A3 = 0; M_RegWrite = 0; M_MemtoReg = 0;
    E_md_start = 0; D_is_md = 0; exc_req = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    E_md_start = 2'b10;
    step();
    reset = 1'b0;
    E_md_start = 2'b00;
    #1;
    total++; if (md_cnt !== 4'd0) begin bad++; $display("FAIL reset_md_cnt got=%0d exp=0", md_cnt); end
    total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_md_busy got=%0b exp=0", md_busy); end
    total++; if (stall_cycles !== 16'd0) begin bad++; $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles); end
    total++; if ({stall_F, stall_D, flush_E, flush_all} !== 4'b0000) begin bad++; $display("FAIL reset_outs got=%b exp=0000", {stall_F, stall_D, flush_E, flush_all}); end
  endtask

  task automatic test_load_use();
    do_reset();
    E_RegWrite = 1; E_MemtoReg = 1; E_A3 = 5; D_rs = 5; D_use_rs = 1;
    #1;
    total++; if ({stall_F, stall_D, flush_E} !== 3'b111) begin bad++; $display("FAIL lu_e_rs got=%b exp=111", {stall_F, stall_D, flush_E}); end
    E_A3 = 0; D_rs = 0;
    #1;
    total++; if ({stall_F, stall_D, flush_E} !== 3'b000) begin bad++; $display("FAIL lu_zero_reg got=%b exp=000", {stall_F, stall_D, flush_E}); end
    E_A3 = 5; D_rs = 5; D_use_rs = 0;
    #1;
    total++; if (stall_F !== 1'b0) begin bad++; $display("FAIL lu_no_use got=%b exp=0", stall_F); end
    D_use_rs = 1; E_MemtoReg = 0;
    #1;
    total++; if (stall_F !== 1'b0) begin bad++; $display("FAIL lu_not_load got=%b exp=0", stall_F); end
    E_RegWrite = 0; M_RegWrite = 1; M_MemtoReg = 1; M_A3 = 7; D_rt = 7; D_use_rt = 1;
    #1;
    total++; if ({stall_F, stall_D, flush_E} !== 3'b111) begin bad++; $display("FAIL lu_m_rt got=%b exp=111", {stall_F, stall_D, flush_E}); end
    exc_req = 1;
    #1;
    total++; if ({stall_F, flush_all} !== 2'b01) begin bad++; $display("FAIL lu_exc_override got=%b exp=01", {stall_F, flush_all}); end
    clear_inputs();
  endtask

  task automatic test_div();
    do_reset();
    E_md_start = 2'b10; D_is_md = 1;
    #1;
    total++; if (stall_F !== 1'b1) begin bad++; $display("FAIL div_start_stall got=%b exp=1", stall_F); end
    step();
    E_md_start = 2'b00;
    for (int i = 10; i >= 1; i--) begin
      #1;
      total++; if (md_cnt !== 4'(i) || md_busy !== 1'b1 || stall_D !== 1'b1)
        begin bad++; $display("FAIL div_count i=%0d got cnt=%0d busy=%b stall=%b", i, md_cnt, md_busy, stall_D); end
      step();
    end
    #1;
    total++; if (md_cnt !== 4'd0 || md_busy !== 1'b0 || stall_D !== 1'b0)
      begin bad++; $display("FAIL div_done got cnt=%0d busy=%b stall=%b exp 0 0 0", md_cnt, md_busy, stall_D); end
    total++; if (stall_cycles !== 16'd11) begin bad++; $display("FAIL div_stall_cycles got=%0d exp=11", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_md_invalid();
    do_reset();
    E_md_start = 2'b11; D_is_md = 1;
    #1;
    total++; if (stall_F !== 1'b0) begin bad++; $display("FAIL md11_stall got=%b exp=0", stall_F); end
    step();
    total++; if (md_cnt !== 4'd0) begin bad++; $display("FAIL md11_cnt got=%0d exp=0", md_cnt); end
    clear_inputs();
  endtask

  task automatic test_exc_start();
    do_reset();
    E_md_start = 2'b01; exc_req = 1; D_is_md = 1;
    #1;
    total++; if ({flush_all, stall_F, stall_D, flush_E} !== 4'b1000) begin bad++; $display("FAIL exc_start_outs got=%b exp=1000", {flush_all, stall_F, stall_D, flush_E}); end
    step();
    clear_inputs();
    E_RegWrite = 1; E_MemtoReg = 1; E_A3 = 3; D_rs = 3; D_use_rs = 1;
    #1;
    total++; if (md_cnt !== 4'd0 || md_busy !== 1'b0) begin bad++; $display("FAIL exc_start_cnt got cnt=%0d busy=%b exp 0 0", md_cnt, md_busy); end
    total++; if (stall_F !== 1'b0) begin bad++; $display("FAIL refill_no_stall got=%b exp=0", stall_F); end
    step();
    total++; if (stall_F !== 1'b1) begin bad++; $display("FAIL after_refill_idle got=%b exp=1", stall_F); end
    clear_inputs();
  endtask

  task automatic test_exc_running();
    do_reset();
    E_md_start = 2'b01;
    step();
    E_md_start = 2'b00;
    total++; if (md_cnt !== 4'd5) begin bad++; $display("FAIL mult_load got=%0d exp=5", md_cnt); end
    step(); step();
    total++; if (md_cnt !== 4'd3) begin bad++; $display("FAIL mult_pre_exc got=%0d exp=3", md_cnt); end
    exc_req = 1; D_is_md = 1;
    #1;
    total++; if ({flush_all, stall_F} !== 2'b10) begin bad++; $display("FAIL exc_run_outs got=%b exp=10", {flush_all, stall_F}); end
    step();
    exc_req = 0;
    #1;
    total++; if (md_cnt !== 4'd2 || md_busy !== 1'b1 || stall_F !== 1'b0)
      begin bad++; $display("FAIL exc_refill got cnt=%0d busy=%b stall=%b exp 2 1 0", md_cnt, md_busy, stall_F); end
    step();
    total++; if (md_cnt !== 4'd1 || stall_F !== 1'b1)
      begin bad++; $display("FAIL exc_resume got cnt=%0d stall=%b exp 1 1", md_cnt, stall_F); end
    step();
    total++; if (md_cnt !== 4'd0 || md_busy !== 1'b0)
      begin bad++; $display("FAIL exc_finish got cnt=%0d busy=%b exp 0 0", md_cnt, md_busy); end
    clear_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    E_RegWrite = 1; E_MemtoReg = 1; E_A3 = 9; D_rt = 9; D_use_rt = 1;
    repeat (65534) step();
    total++; if (stall_cycles !== 16'hFFFE) begin bad++; $display("FAIL sat_near got=%h exp=fffe", stall_cycles); end
    repeat (70000 - 65534) step();
    total++; if (stall_cycles !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", stall_cycles); end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    E_md_start = 2'b10; D_is_md = 1;
    step();
    E_md_start = 2'b00;
    step(); step(); step();
    total++; if (md_cnt !== 4'd7) begin bad++; $display("FAIL mid_pre got=%0d exp=7", md_cnt); end
    reset = 1; E_md_start = 2'b01;
    step();
    reset = 0; E_md_start = 2'b00;
    #1;
    total++; if (md_cnt !== 4'd0 || md_busy !== 1'b0 || stall_cycles !== 16'd0)
      begin bad++; $display("FAIL mid_reset got cnt=%0d busy=%b sc=%0d exp 0 0 0", md_cnt, md_busy, stall_cycles); end
    total++; if (stall_F !== 1'b0) begin bad++; $display("FAIL mid_reset_stall got=%b exp=0", stall_F); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_div();
    test_md_invalid();
    test_exc_start();
    test_exc_running();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have the port CLK, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high; sampled only on the rising edge of CLK.
REQ-003 The block SHALL have the ports D_rs and D_rt, input, 5 bits each: source register numbers of the instruction in the D stage.
REQ-004 The block SHALL have the ports D_use_rs and D_use_rt, input, 1 bit each: the D instruction reads rs/rt in the D stage (branch compare or jr).
REQ-005 The block SHALL have the ports E_A3, input, 5 bits; E_RegWrite, input, 1 bit; E_MemtoReg, input, 1 bit: destination, write enable and load flag of the E-stage instruction.
REQ-006 The block SHALL have the ports M_A3, input, 5 bits; M_RegWrite, input, 1 bit; M_MemtoReg, input, 1 bit: same fields for the M-stage instruction.
REQ-007 The block SHALL have the port E_md_start, input, 2 bits: 00 none, 01 mult/multu, 10 div/divu, 11 treated as 00.
REQ-008 The block SHALL have the port D_is_md, input, 1 bit: the D instruction touches HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
REQ-009 The block SHALL have the port exc_req, input, 1 bit: an interrupt or exception is taken at M this cycle.
REQ-010 The block SHALL have the ports stall_F and stall_D, output, 1 bit each: hold the PC and IF/ID registers.
REQ-011 The block SHALL have the port flush_E, output, 1 bit: load a bubble (all zero) into ID/EX.
REQ-012 The block SHALL have the port flush_all, output, 1 bit: clear IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-013 The block SHALL have the port md_busy, output, 1 bit: the multiply/divide unit is occupied.
REQ-014 The block SHALL have the port md_cnt, output, 4 bits: remaining busy cycles.
REQ-015 The block SHALL have the port stall_cycles, output, 16 bits: saturating count of stalled cycles.

Function
REQ-016 Load-use hazard (LU) SHALL be E_RegWrite & E_MemtoReg & (E_A3!=0) & ((D_use_rs & D_rs==E_A3) | (D_use_rt & D_rt==E_A3)); the same term on M fields with M_MemtoReg SHALL also set LU.
REQ-017 MD hazard (MDH) SHALL be D_is_md & (md_busy | E_md_start in {01,10}).
REQ-018 stall = (LU | MDH) & ~flush_all & (state!=REFILL); stall_F = stall_D = flush_E = stall, all combinational in the same cycle.
REQ-019 flush_all SHALL equal exc_req combinationally and SHALL override every stall output to 0.
REQ-020 The state machine SHALL have three states: IDLE (md_cnt==0), MD_BUSY (md_cnt!=0), and REFILL (one cycle after flush_all).
REQ-021 The IDLE to MD_BUSY transition SHALL occur on a valid E_md_start with exc_req=0, loading md_cnt=5 for mult or 10 for div.
REQ-022 In MD_BUSY, md_cnt SHALL decrement by 1 per cycle and return to IDLE when it reaches 0.
REQ-023 While md_busy=1, E_md_start SHALL be ignored, since MDH guarantees it cannot occur.
REQ-024 E_md_start in the same cycle as exc_req SHALL be suppressed (no load); an MD operation already running SHALL continue counting.
REQ-025 Any state with exc_req=1 SHALL go to REFILL next cycle; REFILL SHALL return to MD_BUSY if md_cnt!=0, else to IDLE, after exactly 1 cycle.
REQ-026 md_busy SHALL be registered and equal (md_cnt!=0).
REQ-027 stall_cycles SHALL increment by 1 on each cycle with stall=1 and saturate at 16'hFFFF without wrapping.
REQ-028 A register number of 0 SHALL never cause LU.

Reset
REQ-029 With reset=1 at a rising edge, next cycle: state=IDLE, md_cnt=0, md_busy=0, stall_cycles=0; all other inputs ignored that edge.
REQ-030 Reset mid-operation (MD_BUSY or REFILL) SHALL abandon the operation with no residual stall.
REQ-031 Combinational outputs SHALL follow their equations during reset; the pipeline registers clear independently on the same reset.
REQ-032 There SHALL be no initial-value dependency beyond reset.

Verification
REQ-033 Scenario: E: lw $5 (E_MemtoReg=1, E_A3=5); D: beq D_rs=5, D_use_rs=1 -> stall_F=stall_D=flush_E=1 for that cycle; the same with E_A3=0 gives 0.
REQ-034 Scenario: E_md_start=10 at cycle t -> md_cnt 10,9,...,1 over t+1..t+10, md_busy=0 at t+11; D mflo held stalled through t+10, stall_cycles=11 (including t).
REQ-035 Scenario: E_md_start=01 with exc_req=1 same cycle -> md_cnt stays 0, flush_all=1, stalls 0, REFILL next cycle, then IDLE.
REQ-036 Scenario: mult running (md_cnt=3), exc_req=1 -> flush_all=1; md_cnt 2 in REFILL, 1 in MD_BUSY, then 0.
REQ-037 Scenario: force stall=1 for 70000 cycles -> stall_cycles=16'hFFFF, no wrap.
REQ-038 Scenario: reset asserted at md_cnt=7 -> next cycle md_cnt=0, md_busy=0, stall_cycles=0, D mfhi not stalled.
